// File: rtl/clk_sel_if.sv
// clk_sel_if: source-select request handshake between the DMA control registers and the sequencer
interface clk_sel_if;
    logic req_valid;
    logic req_sel;
    logic req_ready;
    modport master (output req_valid, req_sel, input req_ready);
    modport slave (input req_valid, req_sel, output req_ready);
endinterface

// File: rtl/clk_sel_seq.sv
// clk_sel_seq: break-before-make enable sequencer for the AXI/pixel glitch-free clock switch
module clk_sel_seq #(
    parameter int OFF_CYC = 8,
    parameter int ON_CYC = 8,
    parameter int HB_MIN = 4,
    parameter int ALIVE_TO = 256,
    parameter int CNT_W = 9
) (
    input  logic      clk0,
    input  logic      clk0_rst_n,
    clk_sel_if.slave  req,
    input  logic      clk1_hb,
    input  logic      err_clr,
    output logic      clk0_enable,
    output logic      clk1_enable,
    output logic      cur_sel,
    output logic      busy,
    output logic      done,
    output logic      err,
    output logic      err_sticky
);
    localparam int HB_W = $clog2(HB_MIN + 1);
    typedef enum logic [2:0] {IDLE, OFF, CHK, ON, FIN} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [HB_W-1:0] hb_cnt, hb_cnt_nx, hb_sum;
    logic [2:0] hb_sync;
    logic target, target_nx, fail, fail_nx, en0_nx, en1_nx, hb_edge, accept;
    assign hb_edge = hb_sync[1] ^ hb_sync[2];
    assign accept = req.req_valid & req.req_ready;
    assign hb_sum = (hb_cnt == HB_W'(HB_MIN)) ? hb_cnt : hb_cnt + HB_W'(hb_edge);
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        hb_cnt_nx = hb_cnt;
        target_nx = target;
        fail_nx = fail;
        en0_nx = clk0_enable;
        en1_nx = clk1_enable;
        case (state)
            IDLE: if (accept) begin
                if (req.req_sel == cur_sel) state_nx = FIN;
                else begin
                    state_nx = OFF;
                    target_nx = req.req_sel;
                    cnt_nx = '0;
                    en0_nx = 1'b0;
                    en1_nx = 1'b0;
                end
            end
            OFF: if (cnt == CNT_W'(OFF_CYC - 1)) begin
                state_nx = target ? CHK : ON;
                cnt_nx = '0;
                hb_cnt_nx = '0;
                en0_nx = ~target;
            end else cnt_nx = cnt + CNT_W'(1);
            CHK: begin
                hb_cnt_nx = hb_sum;
                cnt_nx = cnt + CNT_W'(1);
                // a heartbeat arriving on the timeout cycle still counts as alive
                if (hb_sum == HB_W'(HB_MIN)) begin
                    state_nx = ON;
                    cnt_nx = '0;
                    en1_nx = 1'b1;
                end else if (cnt == CNT_W'(ALIVE_TO - 1)) begin
                    state_nx = ON;
                    cnt_nx = '0;
                    en0_nx = 1'b1;
                    target_nx = 1'b0;
                    fail_nx = 1'b1;
                end
            end
            ON: if (cnt == CNT_W'(ON_CYC - 1)) begin
                state_nx = FIN;
                cnt_nx = '0;
            end else cnt_nx = cnt + CNT_W'(1);
            FIN: begin
                state_nx = IDLE;
                fail_nx = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk0 or negedge clk0_rst_n) begin
        if (!clk0_rst_n) begin
            state <= IDLE;
            cnt <= '0;
            hb_cnt <= '0;
            hb_sync <= '0;
            target <= 1'b0;
            fail <= 1'b0;
            clk0_enable <= 1'b1;
            clk1_enable <= 1'b0;
            cur_sel <= 1'b0;
            req.req_ready <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            hb_cnt <= hb_cnt_nx;
            hb_sync <= {hb_sync[1:0], clk1_hb};
            target <= target_nx;
            fail <= fail_nx;
            clk0_enable <= en0_nx;
            clk1_enable <= en1_nx;
            req.req_ready <= state_nx == IDLE;
            busy <= state_nx != IDLE;
            done <= state == FIN;
            err <= (state == FIN) & fail;
            if (state == FIN) cur_sel <= target;
            err_sticky <= ((state == FIN) & fail) | (err_sticky & ~err_clr);
        end
    end
endmodule

// File: tb/tb_clk_sel_seq.sv
// tb_clk_sel_seq: randomized select requests checked against a timeline model of the switch sequence
module tb_clk_sel_seq;
    localparam int OFF_CYC = 8;
    localparam int ON_CYC = 8;
    localparam int HB_MIN = 4;
    localparam int ALIVE_TO = 256;
    logic clk0 = 1'b0;
    logic clk0_rst_n = 1'b1;
    logic clk1_hb = 1'b0;
    logic err_clr = 1'b0;
    logic clk0_enable, clk1_enable, cur_sel, busy, done, err, err_sticky;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hb_per = 0;
    logic m_cur = 1'b0;
    logic m_sticky = 1'b0;
    clk_sel_if rif();
    clk_sel_seq dut (
        .clk0(clk0),
        .clk0_rst_n(clk0_rst_n),
        .req(rif),
        .clk1_hb(clk1_hb),
        .err_clr(err_clr),
        .clk0_enable(clk0_enable),
        .clk1_enable(clk1_enable),
        .cur_sel(cur_sel),
        .busy(busy),
        .done(done),
        .err(err),
        .err_sticky(err_sticky)
    );
    always #5 clk0 = ~clk0;
    always @(posedge clk0) cyc <= cyc + 1;
    // heartbeat toggles just after every hb_per-th edge; a toggle after edge m is seen by the FSM at edge m+3
    always @(negedge clk0) if (hb_per != 0 && cyc % hb_per == 0) clk1_hb = ~clk1_hb;
    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask
    always @(negedge clk0) if (clk0_rst_n) begin
        check("enables_exclusive", clk0_enable & clk1_enable, 1'b0);
        if (rif.req_ready) check("idle_one_enable", clk0_enable ^ clk1_enable, 1'b1);
    end
    task automatic check_outs(input logic e0, input logic e1, input logic cs, input logic bz,
                              input logic dn, input logic er, input logic st);
        check("clk0_enable", clk0_enable, e0);
        check("clk1_enable", clk1_enable, e1);
        check("cur_sel", cur_sel, cs);
        check("busy", busy, bz);
        check("req_ready", rif.req_ready, ~bz);
        check("done", done, dn);
        check("err", err, er);
        check("err_sticky", err_sticky, st);
    endtask
    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk0);
            check_outs(~m_cur, m_cur, m_cur, 1'b0, 1'b0, 1'b0, m_sticky);
        end
    endtask
    task automatic run_req(input logic sel, input int per, input logic clr_hold);
        int a, on_e, done_e, n;
        logic ok, tgt, same, e0, e1, st;
        hb_per = per;
        @(negedge clk0);
        rif.req_valid = 1'b1;
        rif.req_sel = sel;
        err_clr = clr_hold;
        a = cyc + 1;
        same = sel == m_cur;
        ok = 1'b1;
        tgt = sel;
        on_e = a + OFF_CYC;
        if (same) done_e = a + 1;
        else begin
            if (sel) begin
                n = 0;
                ok = 1'b0;
                on_e = a + OFF_CYC + ALIVE_TO;
                for (int e = a + OFF_CYC + 1; e <= a + OFF_CYC + ALIVE_TO && !ok; e++) begin
                    if (per != 0 && (e - 3) % per == 0) n++;
                    if (n >= HB_MIN) begin
                        ok = 1'b1;
                        on_e = e;
                    end
                end
                if (!ok) tgt = 1'b0;
            end
            done_e = on_e + ON_CYC + 1;
        end
        for (int e = a; e <= done_e; e++) begin
            @(negedge clk0);
            if (same) begin
                e0 = ~m_cur;
                e1 = m_cur;
            end else begin
                e0 = (e >= on_e) & ~tgt;
                e1 = (e >= on_e) & tgt;
            end
            st = (e >= done_e && !ok) ? 1'b1 : (clr_hold ? 1'b0 : m_sticky);
            check_outs(e0, e1, e >= done_e ? tgt : m_cur, e < done_e, e == done_e,
                       e == done_e && !ok, st);
            rif.req_valid = e < done_e ? 1'($urandom_range(0, 1)) : 1'b0;
            rif.req_sel = 1'($urandom_range(0, 1));
            if (e == done_e) err_clr = 1'b0;
        end
        m_cur = tgt;
        m_sticky = !ok ? 1'b1 : (clr_hold ? 1'b0 : m_sticky);
    endtask
    task automatic clear_sticky();
        @(negedge clk0);
        check("sticky_before_clr", err_sticky, m_sticky);
        err_clr = 1'b1;
        @(negedge clk0);
        err_clr = 1'b0;
        m_sticky = 1'b0;
        check("sticky_after_clr", err_sticky, 1'b0);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end
    initial begin
        rif.req_valid = 1'b0;
        rif.req_sel = 1'b0;
        #2 clk0_rst_n = 1'b0;
        repeat (3) @(negedge clk0);
        check_outs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clk0_rst_n = 1'b1;
        idle_check(100);
        run_req(1'b1, 2, 1'b0);
        run_req(1'b1, 3, 1'b0);
        run_req(1'b0, 0, 1'b0);
        run_req(1'b1, 0, 1'b0);
        clear_sticky();
        run_req(1'b0, 0, 1'b0);
        run_req(1'b1, 0, 1'b1);
        clear_sticky();
        for (int i = 0; i < 12; i++) run_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), 1'b0);
        if (m_sticky) clear_sticky();
        if (m_cur) run_req(1'b0, 0, 1'b0);
        hb_per = 0;
        @(negedge clk0);
        rif.req_valid = 1'b1;
        rif.req_sel = 1'b1;
        @(negedge clk0);
        rif.req_valid = 1'b0;
        repeat (20) @(negedge clk0);
        check("busy_in_chk", busy, 1'b1);
        check("clk1_enable_in_chk", clk1_enable, 1'b0);
        #2 clk0_rst_n = 1'b0;
        #1 check_outs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk0);
        clk0_rst_n = 1'b1;
        m_cur = 1'b0;
        m_sticky = 1'b0;
        idle_check(3);
        run_req(1'b1, 2, 1'b0);
        idle_check(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
